// File: rtl/seq_det_sched.sv
// Round-robin scheduler sharing one serial sequence detector between requesters.
// Each granted word is cleared into, shifted through and scored by the detector.
module seq_det_sched #(
  parameter int NREQ  = 2,
  parameter int WIDTH = 8,
  parameter int CNTW  = 4,
  localparam int IDW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*WIDTH-1:0] word,
  output logic [NREQ-1:0]       gnt,
  output logic                  det_clr,
  output logic                  det_x,
  input  logic                  det_y,
  output logic                  busy,
  output logic                  done,
  output logic [IDW-1:0]        done_id,
  output logic [CNTW-1:0]       match_cnt
);

  localparam int BW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE,
    CLEAR,
    SHIFT,
    REPORT
  } state_t;

  state_t           state_q;
  logic [WIDTH-1:0] sh_q;
  logic [CNTW-1:0]  cnt_q;
  logic [CNTW-1:0]  cnt_d;
  logic [IDW-1:0]   id_q;
  logic [IDW-1:0]   ptr_q;
  logic [IDW-1:0]   pick;
  logic [IDW-1:0]   cand;
  logic             hit;
  logic [BW-1:0]    bcnt_q;

  function automatic logic [IDW-1:0] rr_nxt(
    input logic [IDW-1:0] p,
    input int             k
  );
    int s;
    s = int'(p) + k;
    if (s >= NREQ) s = s - NREQ;
    return IDW'(s);
  endfunction

  // Scan from farthest to nearest so the first req after ptr wins.
  always_comb begin
    hit  = 1'b0;
    pick = '0;
    cand = '0;
    for (int k = NREQ; k >= 1; k--) begin
      cand = rr_nxt(ptr_q, k);
      if (req[cand]) begin
        hit  = 1'b1;
        pick = cand;
      end
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (det_y && (cnt_q != '1)) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      sh_q      <= '0;
      cnt_q     <= '0;
      id_q      <= '0;
      ptr_q     <= IDW'(NREQ - 1);
      bcnt_q    <= '0;
      gnt       <= '0;
      det_clr   <= 1'b0;
      det_x     <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      done_id   <= '0;
      match_cnt <= '0;
    end else begin
      gnt     <= '0;
      det_clr <= 1'b0;
      done    <= 1'b0;
      unique case (state_q)
        IDLE: begin
          det_x <= 1'b0;
          if (hit) begin
            sh_q    <= word[int'(pick)*WIDTH +: WIDTH];
            id_q    <= pick;
            ptr_q   <= pick;
            gnt     <= NREQ'(1) << pick;
            cnt_q   <= '0;
            det_clr <= 1'b1;
            busy    <= 1'b1;
            state_q <= CLEAR;
          end
        end
        CLEAR: begin
          det_x   <= sh_q[WIDTH-1];
          sh_q    <= sh_q << 1;
          bcnt_q  <= '0;
          state_q <= SHIFT;
        end
        SHIFT: begin
          cnt_q <= cnt_d;
          // Last bit: the final det_y hit must land in the reported count.
          if (bcnt_q == BW'(WIDTH - 1)) begin
            det_x     <= 1'b0;
            done      <= 1'b1;
            match_cnt <= cnt_d;
            done_id   <= id_q;
            state_q   <= REPORT;
          end else begin
            det_x  <= sh_q[WIDTH-1];
            sh_q   <= sh_q << 1;
            bcnt_q <= bcnt_q + 1'b1;
          end
        end
        REPORT: begin
          busy    <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_det_sched.sv
// Bench for seq_det_sched with an overlapping "101" Mealy detector model.
// Table vectors, scoreboard queue of expected results, and reset/saturation corners.
module tb_seq_det_sched;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [1:0]  req = '0;
  logic [15:0] word = '0;
  logic [1:0]  gnt;
  logic        det_clr;
  logic        det_x;
  logic        det_y;
  logic        busy;
  logic        done;
  logic [0:0]  done_id;
  logic [3:0]  match_cnt;

  logic [0:0]  req2 = '0;
  logic [7:0]  word2 = '0;
  logic [0:0]  gnt2;
  logic        clr2;
  logic        x2;
  logic        busy2;
  logic        done2;
  logic [0:0]  id2;
  logic [2:0]  cnt2;

  always #5 clk = ~clk;

  seq_det_sched #(.NREQ(2), .WIDTH(8), .CNTW(4)) dut (
    .clk(clk), .reset(reset), .req(req), .word(word), .gnt(gnt),
    .det_clr(det_clr), .det_x(det_x), .det_y(det_y), .busy(busy),
    .done(done), .done_id(done_id), .match_cnt(match_cnt)
  );

  seq_det_sched #(.NREQ(1), .WIDTH(8), .CNTW(3)) dut2 (
    .clk(clk), .reset(reset), .req(req2), .word(word2), .gnt(gnt2),
    .det_clr(clr2), .det_x(x2), .det_y(1'b1), .busy(busy2),
    .done(done2), .done_id(id2), .match_cnt(cnt2)
  );

  // Overlapping "101" Mealy detector: 0=none, 1=seen 1, 2=seen 10.
  logic [1:0] ds;
  assign det_y = det_x && (ds == 2'd2);
  always_ff @(posedge clk or posedge reset) begin
    if (reset) ds <= 2'd0;
    else if (det_clr) ds <= 2'd0;
    else if (det_x) ds <= 2'd1;
    else ds <= (ds == 2'd1) ? 2'd2 : 2'd0;
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int done_seen = 0;
  always @(negedge clk) if (done) done_seen <= done_seen + 1;

  typedef struct {
    int id;
    int cnt;
  } exp_t;
  exp_t exp_q[$];

  typedef struct {
    logic [1:0] req;
    logic [7:0] w0;
    logic [7:0] w1;
    int         id;
    int         cnt;
  } vec_t;
  vec_t tbl[6];

  int errors = 0;
  int checks = 0;
  int exp_dones = 0;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic wait_gnt(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (gnt != 2'b00) begin
        ok = 1'b1;
        break;
      end
    end
    check("gnt_seen", 32'(ok), 32'd1);
  endtask

  task automatic pop_cmp();
    exp_t e;
    if (exp_q.size() == 0) begin
      check("sb_empty", 32'd1, 32'd0);
    end else begin
      e = exp_q.pop_front();
      exp_dones++;
      check("done_id", 32'(done_id), 32'(e.id));
      check("match_cnt", 32'(match_cnt), 32'(e.cnt));
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    req = '0;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic run_word(input logic [1:0] r, input logic [7:0] w0,
                          input logic [7:0] w1, input int id, input int cnt);
    bit ok;
    int g;
    logic [7:0] w;
    @(negedge clk);
    req = r;
    word = {w1, w0};
    exp_q.push_back('{id: id, cnt: cnt});
    w = (id == 1) ? w1 : w0;
    wait_gnt(ok);
    if (ok) begin
      g = cyc;
      check("gnt_onehot", 32'(gnt), 32'(2'b01 << id));
      check("clr_pulse", 32'(det_clr), 32'd1);
      check("busy_clr", 32'(busy), 32'd1);
      req = '0;
      word = ~word;
      for (int b = 0; b < 8; b++) begin
        @(negedge clk);
        check($sformatf("det_x_b%0d", b), 32'(det_x), 32'(w[7-b]));
        if (b == 0) check("clr_once", 32'(det_clr), 32'd0);
      end
      @(negedge clk);
      check("done", 32'(done), 32'd1);
      check("done_lat", 32'(cyc - g), 32'd9);
      pop_cmp();
      @(negedge clk);
      check("idle_after", 32'({busy, gnt, done}), 32'd0);
    end
  endtask

  initial begin
    bit ok;
    int last_done;

    tbl[0] = '{req: 2'b01, w0: 8'hAA, w1: 8'h00, id: 0, cnt: 3};
    tbl[1] = '{req: 2'b01, w0: 8'hA5, w1: 8'hFF, id: 0, cnt: 2};
    tbl[2] = '{req: 2'b10, w0: 8'h00, w1: 8'h55, id: 1, cnt: 3};
    tbl[3] = '{req: 2'b01, w0: 8'hB5, w1: 8'h00, id: 0, cnt: 3};
    tbl[4] = '{req: 2'b10, w0: 8'hAA, w1: 8'h00, id: 1, cnt: 0};
    tbl[5] = '{req: 2'b01, w0: 8'hFF, w1: 8'hAA, id: 0, cnt: 0};

    @(negedge clk);
    check("rst_outs", 32'({gnt, det_clr, det_x, busy, done, done_id, match_cnt}), 32'd0);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      check("idle_quiet", 32'({busy, gnt, det_x, det_clr, done}), 32'd0);
    end

    foreach (tbl[i]) run_word(tbl[i].req, tbl[i].w0, tbl[i].w1, tbl[i].id, tbl[i].cnt);

    do_reset();
    req = 2'b11;
    word = {8'hA5, 8'hAA};
    for (int n = 0; n < 4; n++) exp_q.push_back('{id: n % 2, cnt: (n % 2) ? 2 : 3});
    last_done = 0;
    for (int n = 0; n < 4; n++) begin
      wait_gnt(ok);
      if (!ok) break;
      check("rr_order", 32'(gnt), 32'((n % 2) ? 2'b10 : 2'b01));
      if (n == 3) req = '0;
      ok = 1'b0;
      for (int i = 0; i < 30; i++) begin
        @(negedge clk);
        if (done) begin
          ok = 1'b1;
          break;
        end
      end
      check("rr_done_seen", 32'(ok), 32'd1);
      if (!ok) break;
      if (n > 0) check("rr_spacing", 32'(cyc - last_done), 32'd11);
      last_done = cyc;
      pop_cmp();
    end
    req = '0;
    repeat (3) @(negedge clk);

    do_reset();
    req = 2'b01;
    word = {8'h00, 8'hAA};
    wait_gnt(ok);
    req = '0;
    repeat (4) @(negedge clk);
    reset = 1'b1;
    #1;
    check("abort_outs", 32'({gnt, det_clr, det_x, busy, done, done_id, match_cnt}), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      check("abort_quiet", 32'({done, det_clr, busy}), 32'd0);
    end
    run_word(2'b11, 8'hAA, 8'hA5, 0, 3);

    @(negedge clk);
    req2 = 1'b1;
    word2 = 8'h3C;
    ok = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (gnt2 != 1'b0) begin
        ok = 1'b1;
        break;
      end
    end
    check("n1_gnt", 32'(ok), 32'd1);
    req2 = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (done2) begin
        ok = 1'b1;
        break;
      end
    end
    check("n1_done", 32'(ok), 32'd1);
    check("sat_cnt", 32'(cnt2), 32'd7);
    check("n1_id", 32'(id2), 32'd0);

    repeat (5) @(negedge clk);
    check("done_count", 32'(done_seen), 32'(exp_dones));
    check("sb_drained", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
